// File: rtl/afisaj_multiplexat_n.sv
// Multiplexed NUM_DIGITS x 7-segment driver: blanked scan slots, per-frame content latch,
// numeric / turn / hazard / stop modes. Optional macro DISPLAY_DIM_EN adds a PWM brightness input.
module afisaj_multiplexat_n #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 2,
  parameter int unsigned BLINK_DIV    = 250,
  parameter int unsigned LZ_SUPPRESS  = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      stop,
  input  logic                      semnal_stanga,
  input  logic                      semnal_dreapta,
`ifdef DISPLAY_DIM_EN
  input  logic [2:0]                luminozitate,
`endif
  input  logic [4*NUM_DIGITS-1:0]   cifre,
  output logic [NUM_DIGITS-1:0]     digit_en,
  output logic [6:0]                seg,
  output logic                      cadru_nou
);

  localparam int unsigned PW = $clog2(CLK_DIV);
  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam int unsigned BW = $clog2(BLINK_DIV + 1);

  localparam logic [6:0] G_DASH  = 7'h7E;
  localparam logic [6:0] G_BLANK = 7'h7F;
  localparam logic [6:0] G_LEFT  = 7'h30;
  localparam logic [6:0] G_RIGHT = 7'h06;
  localparam logic [6:0] G_STOP  = 7'h00;

  function automatic logic [6:0] bcd_glyph(input logic [3:0] n);
    case (n)
      4'd0:    bcd_glyph = 7'h01;
      4'd1:    bcd_glyph = 7'h4F;
      4'd2:    bcd_glyph = 7'h12;
      4'd3:    bcd_glyph = 7'h06;
      4'd4:    bcd_glyph = 7'h4C;
      4'd5:    bcd_glyph = 7'h24;
      4'd6:    bcd_glyph = 7'h20;
      4'd7:    bcd_glyph = 7'h0F;
      4'd8:    bcd_glyph = 7'h00;
      4'd9:    bcd_glyph = 7'h04;
      default: bcd_glyph = G_DASH;
    endcase
  endfunction

  logic [PW-1:0]                p_q, p_nxt;
  logic [IW-1:0]                i_q, i_nxt;
  logic [BW-1:0]                blink_cnt_q, blink_cnt_nxt;
  logic                         phase_q, phase_nxt;
  logic                         first_q;
  logic [NUM_DIGITS-1:0][6:0]   frame_q, frame_nxt, frame_sel;
  logic                         p_wrap, latch, turn, lead, en_on;
  logic [3:0]                   nib;
  logic [31:0]                  win_end;
  logic [NUM_DIGITS-1:0]        digit_en_nxt;
  logic [6:0]                   seg_nxt;
`ifdef DISPLAY_DIM_EN
  logic [2:0]                   lum_q, lum_sel;
`endif

  // Scan counters, frame content builder, blink bookkeeping and next output values.
  always_comb begin
    p_wrap        = (p_q == PW'(CLK_DIV - 1));
    p_nxt         = p_wrap ? '0 : p_q + PW'(1);
    i_nxt         = i_q;
    turn          = semnal_stanga | semnal_dreapta;
    lead          = (LZ_SUPPRESS != 0);
    nib           = '0;
    frame_nxt     = {NUM_DIGITS{G_BLANK}};
    blink_cnt_nxt = blink_cnt_q;
    phase_nxt     = phase_q;
    win_end       = CLK_DIV;

    if (p_wrap)
      i_nxt = (i_q == IW'(NUM_DIGITS - 1)) ? '0 : i_q + IW'(1);
    latch = first_q | (p_wrap & (i_q == IW'(NUM_DIGITS - 1)));

    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      nib = cifre[4*(NUM_DIGITS-1-d) +: 4];
      if (stop)
        frame_nxt[d] = G_STOP;
      else if (turn) begin
        if (!phase_q)                                   frame_nxt[d] = G_BLANK;
        else if (semnal_stanga && d == 0)               frame_nxt[d] = G_LEFT;
        else if (semnal_dreapta && d == NUM_DIGITS - 1) frame_nxt[d] = G_RIGHT;
        else                                            frame_nxt[d] = G_DASH;
      end else if (lead && nib == 4'd0 && d != NUM_DIGITS - 1)
        frame_nxt[d] = G_BLANK;
      else begin
        frame_nxt[d] = bcd_glyph(nib);
        lead         = 1'b0;
      end
    end

    // Blink phase only runs while the latched mode is a turn/hazard mode.
    if (latch) begin
      if (stop || !turn) begin
        blink_cnt_nxt = '0;
        phase_nxt     = 1'b1;
      end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
        blink_cnt_nxt = '0;
        phase_nxt     = ~phase_q;
      end else
        blink_cnt_nxt = blink_cnt_q + BW'(1);
    end

    frame_sel = latch ? frame_nxt : frame_q;
`ifdef DISPLAY_DIM_EN
    lum_sel = latch ? luminozitate : lum_q;
    win_end = BLANK_CYCLES + ((32'(lum_sel) + 32'd1) * (CLK_DIV - BLANK_CYCLES)) / 32'd8;
`endif

    en_on        = (32'(p_nxt) >= BLANK_CYCLES) && (32'(p_nxt) < win_end);
    digit_en_nxt = en_on ? (NUM_DIGITS'(1) << i_nxt) : '0;
    seg_nxt      = (32'(p_nxt) >= BLANK_CYCLES) ? frame_sel[i_nxt] : G_BLANK;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      p_q         <= '0;
      i_q         <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      first_q     <= 1'b1;
      frame_q     <= {NUM_DIGITS{G_BLANK}};
`ifdef DISPLAY_DIM_EN
      lum_q       <= 3'd7;
`endif
      digit_en    <= '0;
      seg         <= G_BLANK;
      cadru_nou   <= 1'b0;
    end else begin
      p_q         <= p_nxt;
      i_q         <= i_nxt;
      blink_cnt_q <= blink_cnt_nxt;
      phase_q     <= phase_nxt;
      first_q     <= 1'b0;
      if (latch) begin
        frame_q <= frame_nxt;
`ifdef DISPLAY_DIM_EN
        lum_q   <= luminozitate;
`endif
      end
      digit_en    <= digit_en_nxt;
      seg         <= seg_nxt;
      cadru_nou   <= latch;
    end
  end

endmodule
